// File: rtl/asca_test_sequencer_if.sv
// Bus bundle between asca_test_sequencer (master) and its loader, core wrapper
// and dump consumer (slave): program load, ROM write, core control, RAM read, dump stream.
interface asca_test_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  // Program load handshake
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;

  // Instruction ROM write port
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [DATA_W-1:0] rom_wdata;

  // Core control and observation
  logic              core_reset_n;
  logic              core_rom_en;
  logic              core_ram_cen;
  logic [ADDR_W-1:0] pc_out;

  // Data RAM read port
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Dump stream
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    input  ld_valid, ld_data, pc_out, ram_rdata, dump_ready,
    output ld_ready, rom_we, rom_waddr, rom_wdata,
           core_reset_n, core_rom_en, core_ram_cen,
           ram_re, ram_raddr, dump_valid, dump_addr, dump_data
  );

  modport slave (
    output ld_valid, ld_data, pc_out, ram_rdata, dump_ready,
    input  ld_ready, rom_we, rom_waddr, rom_wdata,
           core_reset_n, core_rom_en, core_ram_cen,
           ram_re, ram_raddr, dump_valid, dump_addr, dump_data
  );
endinterface

// File: rtl/asca_test_sequencer.sv
// Run controller for ASCA16 functional tests: load ROM, hold core in reset, run, dump RAM.
// Branch-to-self halt detection is built only when ASCA_TSEQ_HALT_DETECT_EN is defined.
module asca_test_sequencer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned PROG_LEN    = 256,
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned RUN_CYCLES  = 136,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned DUMP_LEN    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  asca_test_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  halted,
  output logic [ADDR_W-1:0]     run_count
);

  localparam logic [ADDR_W-1:0] PROG_LAST = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'(DUMP_LEN - 1);
  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam int unsigned       RUN_W     = $clog2(RUN_CYCLES + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DUMP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] ld_idx;
  logic              ld_fire;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RUN_W-1:0]  run_cyc;
  logic              run_last;
  logic              halt_hit;

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_all;
  logic              rd_fresh;
  logic              rd_go;
  logic [DATA_W-1:0] data_q;
  logic              dump_fire;
  logic              dump_last;

  assign ld_fire   = (state == LOAD) && bus.ld_valid;
  assign run_last  = (run_cyc == RUN_LAST);
  assign dump_fire = bus.dump_valid && bus.dump_ready;
  assign dump_last = dump_fire && (bus.dump_addr == DUMP_LAST);
  // A new read may issue in the same cycle the held word is accepted.
  assign rd_go     = !rd_all && (!bus.dump_valid || bus.dump_ready);

  // The first presentation cycle forwards the RAM output; later stall cycles use the captured copy.
  assign bus.dump_data = rd_fresh ? bus.ram_rdata : data_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)                               state_nx = LOAD;
      LOAD:    if (ld_fire && (ld_idx == PROG_LAST))    state_nx = HOLD;
      HOLD:    if (hold_cnt == HOLD_LAST)               state_nx = RUN;
      RUN:     if (run_last || halt_hit)                state_nx = DUMP;
      DUMP:    if (dump_last)                           state_nx = IDLE;
      default:                                          state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.ld_ready     = 1'b0;
    bus.rom_we       = 1'b0;
    bus.rom_waddr    = ld_idx;
    bus.rom_wdata    = '0;
    bus.core_reset_n = 1'b0;
    bus.core_rom_en  = 1'b0;
    bus.core_ram_cen = 1'b0;
    bus.ram_re       = 1'b0;
    bus.ram_raddr    = rd_idx;
    busy             = (state != IDLE);
    unique case (state)
      LOAD: begin
        bus.ld_ready  = 1'b1;
        bus.rom_we    = bus.ld_valid;
        bus.rom_wdata = bus.ld_valid ? bus.ld_data : '0;
      end
      RUN: begin
        bus.core_reset_n = 1'b1;
        bus.core_rom_en  = 1'b1;
        bus.core_ram_cen = 1'b1;
      end
      DUMP: begin
        bus.ram_re = rd_go;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load / hold / run counters and run status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_idx    <= '0;
      hold_cnt  <= '0;
      run_cyc   <= '0;
      run_count <= '0;
      halted    <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == LOAD) begin
        if (ld_fire) begin
          ld_idx <= ld_idx + 1'b1;
        end
      end else begin
        ld_idx <= '0;
      end

      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      run_cyc  <= (state == RUN)  ? run_cyc + 1'b1  : '0;

      if ((state == IDLE) && start) begin
        halted    <= 1'b0;
        run_count <= '0;
      end else if (state == RUN) begin
        if (run_count != '1) begin
          run_count <= run_count + 1'b1;
        end
        if (halt_hit) begin
          halted <= 1'b1;
        end
      end

      done <= (state == DUMP) && dump_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Dump read pipeline: one read outstanding, output held until accepted
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || (state != DUMP)) begin
      rd_idx         <= '0;
      rd_all         <= 1'b0;
      rd_fresh       <= 1'b0;
      data_q         <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_addr  <= '0;
    end else begin
      rd_fresh <= bus.ram_re;
      if (rd_fresh) begin
        data_q <= bus.ram_rdata;
      end
      if (bus.ram_re) begin
        bus.dump_valid <= 1'b1;
        bus.dump_addr  <= rd_idx;
        if (rd_idx == DUMP_LAST) begin
          rd_all <= 1'b1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end else if (dump_fire) begin
        bus.dump_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Halt detection
  // ---------------------------------------------------------------------------
`ifdef ASCA_TSEQ_HALT_DETECT_EN
  localparam int unsigned     EQ_W    = $clog2(HALT_REPEAT);
  localparam logic [EQ_W-1:0] EQ_LAST = EQ_W'(HALT_REPEAT - 2);

  logic [ADDR_W-1:0] pc_prev;
  logic              pc_prev_ok;
  logic [EQ_W-1:0]   eq_cnt;
  logic              pc_same;

  // HALT_REPEAT equal samples means HALT_REPEAT-1 consecutive matching comparisons.
  assign pc_same  = pc_prev_ok && (bus.pc_out == pc_prev);
  assign halt_hit = (state == RUN) && pc_same && (eq_cnt == EQ_LAST);

  always_ff @(posedge clk) begin
    if (reset || (state != RUN)) begin
      pc_prev    <= '0;
      pc_prev_ok <= 1'b0;
      eq_cnt     <= '0;
    end else begin
      pc_prev    <= bus.pc_out;
      pc_prev_ok <= 1'b1;
      eq_cnt     <= pc_same ? eq_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_pc;

  assign halt_hit  = 1'b0;
  assign unused_pc = ^bus.pc_out;
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_dump_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.dump_valid && !bus.dump_ready) |=>
      (bus.dump_valid && $stable(bus.dump_addr) && $stable(bus.dump_data)));

  a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
    bus.ram_re |-> (!bus.dump_valid || bus.dump_ready));

endmodule

// File: tb/tb_asca_test_sequencer.sv
// Scoreboard bench for asca_test_sequencer: directed runs with gapped load, back-pressure,
// halt pattern, mid-run reset and held start; monitors pop expected ROM writes and dump words.
module tb_asca_test_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

`ifdef ASCA_TSEQ_HALT_DETECT_EN
  localparam int   EXP_HALT_RUN = 14;
  localparam logic EXP_HALTED   = 1'b1;
`else
  localparam int   EXP_HALT_RUN = 136;
  localparam logic EXP_HALTED   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          halted;
  logic [AW-1:0] run_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] tb_rc = '0;
  logic        halt_mode = 1'b0;
  int          stall_left = 0;
  logic [15:0] prog [4];
  logic [15:0] ram_mem [4];
  logic [31:0] exp_rom [$];
  logic [31:0] exp_dump [$];
  logic [31:0] mon_e;
  logic        held = 1'b0;
  logic [15:0] held_addr;
  logic [15:0] held_data;

  asca_test_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  asca_test_sequencer #(
    .DATA_W(DW), .ADDR_W(AW), .PROG_LEN(4), .HOLD_CYCLES(3),
    .RUN_CYCLES(136), .HALT_REPEAT(4), .DUMP_LEN(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .halted(halted), .run_count(run_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Core model: pc counts RUN cycles; in halt mode it sticks at 0x0020 from RUN cycle 10.
  always @(posedge clk) tb_rc <= bus.core_reset_n ? tb_rc + 16'd1 : 16'd0;
  assign bus.pc_out = (halt_mode && (tb_rc >= 16'd10)) ? 16'h0020 : tb_rc;

  initial bus.ram_rdata = '0;
  always @(posedge clk) if (bus.ram_re) bus.ram_rdata <= ram_mem[bus.ram_raddr[1:0]];

  // Consumer: stalls word 1 for stall_left cycles, otherwise always ready.
  initial begin
    bus.dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.dump_valid && (bus.dump_addr == 16'd1) && (stall_left > 0)) begin
        bus.dump_ready = 1'b0;
        stall_left--;
      end else begin
        bus.dump_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (bus.rom_we) begin
        check("rom_we_expected", 32'(exp_rom.size() != 0), 32'd1);
        if (exp_rom.size() != 0) begin
          mon_e = exp_rom.pop_front();
          check("rom_waddr", 32'(bus.rom_waddr), 32'(mon_e[31:16]));
          check("rom_wdata", 32'(bus.rom_wdata), 32'(mon_e[15:0]));
        end
      end
      if (bus.dump_valid) begin
        if (held) begin
          check("dump_addr_stable", 32'(bus.dump_addr), 32'(held_addr));
          check("dump_data_stable", 32'(bus.dump_data), 32'(held_data));
        end
        if (bus.dump_ready) begin
          held = 1'b0;
          check("dump_expected", 32'(exp_dump.size() != 0), 32'd1);
          if (exp_dump.size() != 0) begin
            mon_e = exp_dump.pop_front();
            check("dump_addr", 32'(bus.dump_addr), 32'(mon_e[31:16]));
            check("dump_data", 32'(bus.dump_data), 32'(mon_e[15:0]));
          end
        end else begin
          held      = 1'b1;
          held_addr = bus.dump_addr;
          held_data = bus.dump_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic do_run(input logic hold_start, input logic halt, input int stalls,
                        input int abort_at, input int exp_run, input logic exp_halted);
    int n;
    int k;
    halt_mode    = halt;
    stall_left   = stalls;
    bus.ld_valid = 1'b0;
    start        = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    check("ld_ready_after_start", 32'(bus.ld_ready), 32'd1);
    check("busy_in_load", 32'(busy), 32'd1);

    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b0;
      bus.ld_data  = 16'hDEAD;
      @(posedge clk); #1;
      bus.ld_valid = 1'b1;
      bus.ld_data  = prog[i];
      exp_rom.push_back({16'(i), prog[i]});
      @(posedge clk); #1;
    end
    bus.ld_data = 16'hBAD0;
    check("hold_rom_en", 32'({bus.core_rom_en, bus.core_ram_cen}), 32'd0);

    n = 0;
    while (!bus.core_reset_n && (n < 20)) begin
      n++;
      @(posedge clk); #1;
    end
    check("hold_cycles", 32'(n), 32'd3);
    check("rom_queue_drained", 32'(exp_rom.size()), 32'd0);
    check("run_enables", 32'({bus.core_rom_en, bus.core_ram_cen}), 32'd3);

    n = 0;
    while (bus.core_reset_n && (n < 1000)) begin
      if ((abort_at >= 0) && (n == abort_at)) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_core_reset_n", 32'(bus.core_reset_n), 32'd0);
        check("abort_run_count", 32'(run_count), 32'd0);
        check("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
      n++;
      @(posedge clk); #1;
    end
    check("run_cycles", 32'(n), 32'(exp_run));
    check("run_count", 32'(run_count), 32'(exp_run));
    check("halted", 32'(halted), 32'(exp_halted));
    check("dump_core_reset_n", 32'(bus.core_reset_n), 32'd0);
    check("first_ram_re", 32'(bus.ram_re), 32'd1);

    exp_dump.push_back({16'd0, 16'h00A0});
    exp_dump.push_back({16'd1, 16'h00A1});
    exp_dump.push_back({16'd2, 16'h00A2});
    k = 0;
    while (!done && (k < 100)) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("dump_cycles_to_done", 32'(k), 32'(4 + stalls));
    check("done_pulse", 32'(done), 32'd1);
    check("dump_queue_drained", 32'(exp_dump.size()), 32'd0);
    @(posedge clk); #1;
    check("done_single", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("run_count_held", 32'(run_count), 32'(exp_run));
    check("halted_held", 32'(halted), 32'(exp_halted));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;
    ram_mem[0] = 16'h00A0; ram_mem[1] = 16'h00A1; ram_mem[2] = 16'h00A2; ram_mem[3] = 16'h00BB;
    reset        = 1'b1;
    start        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reset_n", 32'(bus.core_reset_n), 32'd0);
    check("rst_strobes", 32'({bus.ld_ready, bus.rom_we, bus.core_rom_en, bus.core_ram_cen,
                              bus.ram_re, bus.dump_valid, busy, done}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_run_count", 32'(run_count), 32'd0);
    check("rst_addrs", 32'({bus.rom_waddr, bus.ram_raddr}), 32'd0);
    check("rst_dump_addr_data", 32'({bus.dump_addr, bus.dump_data}), 32'd0);
    reset = 1'b0;

    do_run(1'b0, 1'b0, 5, -1, 136, 1'b0);
    do_run(1'b1, 1'b1, 0, -1, EXP_HALT_RUN, EXP_HALTED);
    do_run(1'b0, 1'b0, 0, 50, 0, 1'b0);
    do_run(1'b0, 1'b0, 0, -1, 136, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
